instr_fetch_unit: RTL and testbench

//  Producer side of the decoder interface. Fetches 32-bit instructions from instruction memory

---
 rtl/instr_fetch_unit.sv | 189 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues single-outstanding fetches to instruction
// memory (req/gnt/rvalid), buffers returned words in a small prefetch FIFO and
// presents the head to the decoder with a valid/ready handshake.
// Build option: define IFU_IDLE_GATE_EN to force instr/instr_pc to zero while
// instr_valid is low. Without it the outputs hold the last head word.
//
// state | meaning
// IDLE  | no request outstanding, issue when a FIFO slot is free
// REQ   | imem_req high, waiting for imem_gnt (discard may already be set)
// WAIT  | granted, waiting for rvalid, response will be pushed
// DROP  | granted, waiting for rvalid, response will be discarded

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        dec_enable
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t        state;
  logic          discard;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;

  logic [31:0]   mem_instr [FIFO_DEPTH];
  logic [31:0]   mem_pc    [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [31:0]   head_instr;
  logic [31:0]   head_pc;

  logic          push;
  logic          pop;
  logic [CW-1:0] remaining;
  logic [CW-1:0] count_nxt;
  logic [PW-1:0] rd_ptr_nxt;
  logic [31:0]   redirect_pc_al;

  // FIFO bookkeeping; redirect suppresses both push and pop
  always_comb begin
    push           = (state == WAIT) && imem_rvalid && !redirect;
    pop            = instr_valid && instr_ready && !redirect;
    remaining      = count - CW'(pop);
    count_nxt      = remaining + CW'(push);
    rd_ptr_nxt     = rd_ptr + PW'(pop);
    redirect_pc_al = redirect_pc & ~32'h3;
  end

  // Fetch FSM: request issue, grant tracking and response discard after redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      discard   <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_pc  <= RESET_PC;
      req_pc    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (!redirect && (count < DEPTH_C)) begin
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
            state     <= REQ;
          end
        end
        REQ: begin
          if (imem_gnt) begin
            imem_req <= 1'b0;
            req_pc   <= imem_addr;
            if (discard || redirect) begin
              discard <= 1'b1;
              state   <= DROP;
            end else begin
              fetch_pc <= imem_addr + 32'd4;
              state    <= WAIT;
            end
          end else if (redirect) begin
            // request stays on the bus unchanged; its data is thrown away later
            discard <= 1'b1;
          end
        end
        WAIT: begin
          if (redirect) begin
            if (imem_rvalid) begin
              state <= IDLE;
            end else begin
              discard <= 1'b1;
              state   <= DROP;
            end
          end else if (imem_rvalid) begin
            if (count_nxt < DEPTH_C) begin
              imem_req  <= 1'b1;
              imem_addr <= fetch_pc;
              state     <= REQ;
            end else begin
              state <= IDLE;
            end
          end
        end
        DROP: begin
          if (imem_rvalid) begin
            discard <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (redirect) fetch_pc <= redirect_pc_al;
    end
  end

  // Prefetch storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_instr[i] <= 32'h0;
        mem_pc[i]    <= 32'h0;
      end
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= imem_rdata;
        mem_pc[wr_ptr]    <= req_pc;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
    end
  end

  // Registered head: holds the last word when the FIFO drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      head_instr  <= 32'h0;
      head_pc     <= 32'h0;
    end else if (redirect) begin
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= (remaining != '0) || push;
      if (remaining != '0) begin
        head_instr <= mem_instr[rd_ptr_nxt];
        head_pc    <= mem_pc[rd_ptr_nxt];
      end else if (push) begin
        head_instr <= imem_rdata;
        head_pc    <= req_pc;
      end
    end
  end

  assign dec_enable = instr_valid;

`ifdef IFU_IDLE_GATE_EN
  assign instr    = instr_valid ? head_instr : 32'h0;
  assign instr_pc = instr_valid ? head_pc    : 32'h0;
`else
  assign instr    = head_instr;
  assign instr_pc = head_pc;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a main instance (RESET_PC=0) served by a
// latency-programmable memory model, and a second instance (RESET_PC near the
// top of the address space) driven by hand for the wrap and idle-output cases.

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr, instr_pc;
  logic        instr_valid, instr_ready, dec_enable;

  logic        imem_req_w, imem_gnt_w, imem_rvalid_w;
  logic [31:0] imem_addr_w, imem_rdata_w;
  logic        redirect_w;
  logic [31:0] redirect_pc_w;
  logic [31:0] instr_w, instr_pc_w;
  logic        instr_valid_w, instr_ready_w, dec_enable_w;

  int tests = 0;
  int fails = 0;
  int lat   = 1;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .dec_enable(dec_enable)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_gnt(imem_gnt_w),
    .imem_rvalid(imem_rvalid_w), .imem_rdata(imem_rdata_w),
    .redirect(redirect_w), .redirect_pc(redirect_pc_w),
    .instr(instr_w), .instr_pc(instr_pc_w), .instr_valid(instr_valid_w),
    .instr_ready(instr_ready_w), .dec_enable(dec_enable_w)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  // memory model for u_dut: grants any request, answers lat cycles later
  initial begin
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    pend = 1'b0; cnt = 0; paddr = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else if (pend) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = word_of(paddr);
          pend        = 1'b0;
        end else begin
          cnt--;
        end
      end else if (imem_req) begin
        imem_gnt = 1'b1;
        pend     = 1'b1;
        paddr    = imem_addr;
        cnt      = lat - 1;
      end
    end
  end

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(output logic [31:0] a, output bit ok);
    ok = 1'b0;
    a  = 32'h0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) begin
        ok = 1'b1;
        a  = imem_addr;
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] a;
    bit ok;
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({imem_req, instr_valid, dec_enable} !== 3'b000 || imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_ctrl: req/valid/en=%b addr=%h, expected 000 addr=00000000",
               {imem_req, instr_valid, dec_enable}, imem_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_first_req: req=%b addr=%h, expected 1 00000000", imem_req, imem_addr);
    end
    lat = 1;
    instr_ready = 1'b0;
    repeat (6) @(negedge clk);
    tests++;
    if (instr_valid !== 1'b1) begin
      fails++;
      $display("FAIL reset_precond_valid: valid=%b, expected 1", instr_valid);
    end
    wait_grant(a, ok);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({imem_req, instr_valid, dec_enable} !== 3'b000) begin
      fails++;
      $display("FAIL reset_mid_ctrl: req/valid/en=%b, expected 000", {imem_req, instr_valid, dec_enable});
    end
    tests++;
    if (imem_addr !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid_data: addr=%h instr=%h pc=%h, expected all 0", imem_addr, instr, instr_pc);
    end
    tests++;
    if (imem_addr_w !== 32'hFFFF_FFF8 || imem_req_w !== 1'b0) begin
      fails++;
      $display("FAIL reset_wrap_inst: addr=%h req=%b, expected FFFFFFF8 0", imem_addr_w, imem_req_w);
    end
    instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: req=%b addr=%h valid=%b, expected 1 00000000 0",
               imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_stream;
    logic [31:0] gaddr [4];
    logic [31:0] ppc [4];
    logic [31:0] pdat [4];
    int ng, np;
    logic [31:0] e;
    ng = 0; np = 0;
    lat = 1;
    instr_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (imem_req && imem_gnt && ng < 4) begin
        gaddr[ng] = imem_addr;
        ng++;
      end
      if (instr_valid && instr_ready && np < 4) begin
        ppc[np]  = instr_pc;
        pdat[np] = instr;
        np++;
        tests++;
        if (dec_enable !== 1'b1) begin
          fails++;
          $display("FAIL stream_dec_enable: dec_enable=%b, expected 1", dec_enable);
        end
      end
    end
    tests++;
    if (ng != 4 || np != 4) begin
      fails++;
      $display("FAIL stream_counts: grants=%0d pops=%0d, expected 4 4", ng, np);
    end else begin
      for (int i = 0; i < 4; i++) begin
        e = 32'(i * 4);
        tests++;
        if (gaddr[i] !== e || ppc[i] !== e || pdat[i] !== word_of(e)) begin
          fails++;
          $display("FAIL stream_%0d: addr=%h pc=%h data=%h, expected %h %h %h",
                   i, gaddr[i], ppc[i], pdat[i], e, e, word_of(e));
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] gaddr [4];
    logic [31:0] a;
    bit ok;
    int ng;
    ng = 0;
    lat = 1;
    instr_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (imem_req && imem_gnt && ng < 4) begin
        gaddr[ng] = imem_addr;
        ng++;
      end
    end
    tests++;
    if (ng != 2 || gaddr[0] !== 32'h0 || gaddr[1] !== 32'h4) begin
      fails++;
      $display("FAIL bp_grants: count=%0d first=%h second=%h, expected 2 00000000 00000004",
               ng, gaddr[0], gaddr[1]);
    end
    tests++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_stall: req=%b valid=%b, expected 0 1", imem_req, instr_valid);
    end
    tests++;
    if (instr_pc !== 32'h0 || instr !== word_of(32'h0)) begin
      fails++;
      $display("FAIL bp_head: pc=%h instr=%h, expected 00000000 %h", instr_pc, instr, word_of(32'h0));
    end
    instr_ready = 1'b1;
    wait_grant(a, ok);
    tests++;
    if (!ok || a !== 32'h8) begin
      fails++;
      $display("FAIL bp_resume: ok=%0d addr=%h, expected 1 00000008", ok, a);
    end
  endtask

  task automatic test_redirect;
    logic [31:0] a, gfirst, pfirst, dfirst;
    bit ok, gseen, pseen;
    lat = 3;
    instr_ready = 1'b1;
    do_reset();
    wait_grant(a, ok);
    tests++;
    if (!ok || a !== 32'h0) begin
      fails++;
      $display("FAIL redir_first_grant: ok=%0d addr=%h, expected 1 00000000", ok, a);
    end
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    @(negedge clk);
    redirect = 1'b0;
    tests++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL redir_drop_state: req=%b valid=%b, expected 0 0", imem_req, instr_valid);
    end
    gseen = 1'b0; pseen = 1'b0;
    gfirst = 32'h0; pfirst = 32'h0; dfirst = 32'h0;
    for (int c = 0; c < 40 && !(gseen && pseen); c++) begin
      @(negedge clk);
      if (imem_req && imem_gnt && !gseen) begin
        gseen  = 1'b1;
        gfirst = imem_addr;
      end
      if (instr_valid && instr_ready && !pseen) begin
        pseen  = 1'b1;
        pfirst = instr_pc;
        dfirst = instr;
      end
    end
    tests++;
    if (!gseen || gfirst !== 32'h100) begin
      fails++;
      $display("FAIL redir_next_addr: seen=%0d addr=%h, expected 1 00000100", gseen, gfirst);
    end
    tests++;
    if (!pseen || pfirst !== 32'h100 || dfirst !== word_of(32'h100)) begin
      fails++;
      $display("FAIL redir_no_gap: seen=%0d pc=%h data=%h, expected 1 00000100 %h",
               pseen, pfirst, dfirst, word_of(32'h100));
    end
    lat = 1;
    instr_ready = 1'b0;
    repeat (14) @(negedge clk);
    tests++;
    if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
      fails++;
      $display("FAIL redir_full_precond: valid=%b req=%b, expected 1 0", instr_valid, imem_req);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0203;
    @(negedge clk);
    redirect = 1'b0;
    tests++;
    if (instr_valid !== 1'b0 || dec_enable !== 1'b0) begin
      fails++;
      $display("FAIL redir_flush: valid=%b en=%b, expected 0 0", instr_valid, dec_enable);
    end
    instr_ready = 1'b1;
    wait_grant(a, ok);
    tests++;
    if (!ok || a !== 32'h200) begin
      fails++;
      $display("FAIL redir_idle_addr: ok=%0d addr=%h, expected 1 00000200", ok, a);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_a [3];
    exp_a[0] = 32'hFFFF_FFF8;
    exp_a[1] = 32'hFFFF_FFFC;
    exp_a[2] = 32'h0000_0000;
    instr_ready_w = 1'b1;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 20 && !imem_req_w; k++) @(negedge clk);
      tests++;
      if (imem_req_w !== 1'b1 || imem_addr_w !== exp_a[i]) begin
        fails++;
        $display("FAIL wrap_addr_%0d: req=%b addr=%h, expected 1 %h", i, imem_req_w, imem_addr_w, exp_a[i]);
      end
      imem_gnt_w = 1'b1;
      @(negedge clk);
      imem_gnt_w    = 1'b0;
      imem_rvalid_w = 1'b1;
      imem_rdata_w  = word_of(exp_a[i]);
      @(negedge clk);
      imem_rvalid_w = 1'b0;
      tests++;
      if (instr_valid_w !== 1'b1 || instr_pc_w !== exp_a[i] || instr_w !== word_of(exp_a[i])) begin
        fails++;
        $display("FAIL wrap_head_%0d: valid=%b pc=%h instr=%h, expected 1 %h %h",
                 i, instr_valid_w, instr_pc_w, instr_w, exp_a[i], word_of(exp_a[i]));
      end
    end
  endtask

  task automatic test_idle_gate;
    logic [31:0] e;
`ifdef IFU_IDLE_GATE_EN
    e = 32'h0;
`else
    e = word_of(32'h0);
`endif
    @(negedge clk);
    tests++;
    if (instr_valid_w !== 1'b0 || dec_enable_w !== 1'b0) begin
      fails++;
      $display("FAIL gate_valid: valid=%b en=%b, expected 0 0", instr_valid_w, dec_enable_w);
    end
    tests++;
    if (instr_w !== e) begin
      fails++;
      $display("FAIL gate_instr: instr=%h, expected %h", instr_w, e);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    instr_ready   = 1'b1;
    redirect      = 1'b0;
    redirect_pc   = 32'h0;
    imem_gnt_w    = 1'b0;
    imem_rvalid_w = 1'b0;
    imem_rdata_w  = 32'h0;
    redirect_w    = 1'b0;
    redirect_pc_w = 32'h0;
    instr_ready_w = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_idle_gate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
